// File: rtl/matrix_job_pkg.sv
// Shared types and default sizing for the matrix job arbiter.
package matrix_job_pkg;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned AW_DEF   = 16;
    localparam int unsigned CW_DEF   = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_COMPLETE
    } state_t;

    // Job descriptor at the default address/count widths.
    typedef struct packed {
        logic [AW_DEF-1:0] matrix;
        logic [AW_DEF-1:0] vector;
        logic [AW_DEF-1:0] out;
        logic [CW_DEF-1:0] count;
    } job_desc_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or above ptr, wrapping to 0.
module rr_arbiter #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int unsigned cand;

    always_comb begin : pick
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (32'(ptr) + k) % NREQ;
            if (!any && req[IW'(cand)]) begin
                any               = 1'b1;
                idx               = IW'(cand);
                grant[IW'(cand)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/matrix_job_arbiter.sv
// Arbitrates matrix-vector jobs from NREQ requesters onto one processor,
// one job in flight at a time, and reports completion back to the owner.
module matrix_job_arbiter
    import matrix_job_pkg::*;
#(
    parameter  int unsigned NREQ = NREQ_DEF,
    parameter  int unsigned AW   = AW_DEF,
    parameter  int unsigned CW   = CW_DEF,
    localparam int unsigned IW   = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  logic [NREQ*AW-1:0] req_matrix_addr,
    input  logic [NREQ*AW-1:0] req_vector_addr,
    input  logic [NREQ*AW-1:0] req_out_addr,
    input  logic [NREQ*CW-1:0] req_count,
    output logic             mp_start,
    output logic [AW-1:0]    mp_matrix_addr,
    output logic [AW-1:0]    mp_vector_addr,
    output logic [AW-1:0]    mp_out_addr,
    output logic [CW-1:0]    mp_count,
    input  logic             mp_done,
    output logic             done_valid,
    output logic [IW-1:0]    done_id,
    output logic             busy,
    output logic             err_spurious
);

    // Same layout as job_desc_t, sized by this instance's parameters.
    typedef struct packed {
        logic [AW-1:0] matrix;
        logic [AW-1:0] vector;
        logic [AW-1:0] out;
        logic [CW-1:0] count;
    } desc_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, id_q, grant_idx, ptr_next;
    logic [NREQ-1:0] grant;
    logic            grant_any, accept, spurious, err_q;
    desc_t           desc_q, desc_sel;

    rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    always_comb begin : desc_mux
        desc_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                desc_sel.matrix = req_matrix_addr[i*AW +: AW];
                desc_sel.vector = req_vector_addr[i*AW +: AW];
                desc_sel.out    = req_out_addr[i*AW +: AW];
                desc_sel.count  = req_count[i*CW +: CW];
            end
        end
    end

    assign ptr_next = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
    // Any done outside WAIT (including the mp_start cycle) is unexpected.
    assign spurious = mp_done && (state_q != ST_WAIT);

    always_comb begin : fsm_next
        state_d    = state_q;
        req_ready  = '0;
        mp_start   = 1'b0;
        done_valid = 1'b0;
        accept     = 1'b0;
        busy       = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                req_ready = grant;
                if (grant_any) begin
                    accept  = 1'b1;
                    state_d = (desc_sel.count == '0) ? ST_COMPLETE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mp_start = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (mp_done) state_d = ST_COMPLETE;
            end
            ST_COMPLETE: begin
                done_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!rst_n) begin
            req_ready  = '0;
            mp_start   = 1'b0;
            done_valid = 1'b0;
            busy       = 1'b0;
            accept     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin : regs
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            desc_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                desc_q   <= desc_sel;
                id_q     <= grant_idx;
                rr_ptr_q <= ptr_next;
            end
            if (spurious) err_q <= 1'b1;
        end
    end

    assign mp_matrix_addr = desc_q.matrix;
    assign mp_vector_addr = desc_q.vector;
    assign mp_out_addr    = desc_q.out;
    assign mp_count       = desc_q.count;
    assign done_id        = id_q;
    assign err_spurious   = err_q;

endmodule

// File: tb/tb_matrix_job_arbiter.sv
// Self-checking bench for matrix_job_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_matrix_job_arbiter;
    import matrix_job_pkg::*;

    localparam int NREQ = 4;
    localparam int AW   = 16;
    localparam int CW   = 8;
    localparam int IW   = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*AW-1:0] req_matrix_addr, req_vector_addr, req_out_addr;
    logic [NREQ*CW-1:0] req_count;
    logic              mp_start, mp_done, done_valid, busy, err_spurious;
    logic [AW-1:0]     mp_matrix_addr, mp_vector_addr, mp_out_addr;
    logic [CW-1:0]     mp_count;
    logic [IW-1:0]     done_id;

    logic [AW-1:0] m_a [NREQ];
    logic [AW-1:0] v_a [NREQ];
    logic [AW-1:0] o_a [NREQ];
    logic [CW-1:0] cnt [NREQ];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_ptr  = 0;
    logic exp_err  = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_matrix_addr[i*AW +: AW] = m_a[i];
            req_vector_addr[i*AW +: AW] = v_a[i];
            req_out_addr[i*AW +: AW]    = o_a[i];
            req_count[i*CW +: CW]       = cnt[i];
        end
    end

    matrix_job_arbiter #(.NREQ(NREQ), .AW(AW), .CW(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_matrix_addr (req_matrix_addr),
        .req_vector_addr (req_vector_addr),
        .req_out_addr    (req_out_addr),
        .req_count       (req_count),
        .mp_start        (mp_start),
        .mp_matrix_addr  (mp_matrix_addr),
        .mp_vector_addr  (mp_vector_addr),
        .mp_out_addr     (mp_out_addr),
        .mp_count        (mp_count),
        .mp_done         (mp_done),
        .done_valid      (done_valid),
        .done_id         (done_id),
        .busy            (busy),
        .err_spurious    (err_spurious)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference winner: first valid requester scanning upward from p with wrap.
    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        int c;
        for (int k = 0; k < NREQ; k++) begin
            c = (p + k) % NREQ;
            if (v[IW'(c)]) return c;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0; req_valid = '0; mp_done = 1'b0;
        step();
        rst_n = 1'b1;
        exp_ptr = 0; exp_err = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NREQ; i++) begin
            m_a[i] = '0; v_a[i] = '0; o_a[i] = '0; cnt[i] = 8'd1;
        end
        rst_n = 1'b0; req_valid = '1; mp_done = 1'b1;
        step();
        mp_done = 1'b0;
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        n_checks++; if ({busy, mp_start, done_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_outs busy/start/done got=%b exp=000", {busy, mp_start, done_valid}); end
        n_checks++; if (err_spurious !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err_spurious); end
        n_checks++; if ({mp_matrix_addr, mp_count, done_id} !== '0) begin n_fail++; $display("FAIL reset_latched got=%h/%h/%0d exp=0", mp_matrix_addr, mp_count, done_id); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_accept got=%b exp=0001", req_ready); end
        req_valid = '0;
        step();
        exp_ptr = 0; exp_err = 1'b0;
    endtask

    task automatic test_single();
        m_a[2] = 16'h0100; v_a[2] = 16'h0200; o_a[2] = 16'h0300; cnt[2] = 8'd5;
        req_valid = 4'b0100;
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
        step();
        req_valid = '0;
        n_checks++; if (mp_start !== 1'b1) begin n_fail++; $display("FAIL single_start got=%b exp=1", mp_start); end
        n_checks++; if ({mp_matrix_addr, mp_vector_addr, mp_out_addr, mp_count} !== {16'h0100, 16'h0200, 16'h0300, 8'd5})
            begin n_fail++; $display("FAIL single_desc got=%h/%h/%h/%0d exp=0100/0200/0300/5", mp_matrix_addr, mp_vector_addr, mp_out_addr, mp_count); end
        for (int c = 1; c < 10; c++) begin
            step();
            n_checks++; if ({mp_start, done_valid, busy} !== 3'b001) begin n_fail++; $display("FAIL single_wait c=%0d start/done/busy got=%b exp=001", c, {mp_start, done_valid, busy}); end
        end
        step();
        mp_done = 1'b1;
        step();
        mp_done = 1'b0;
        n_checks++; if ({done_valid, done_id} !== {1'b1, 2'd2}) begin n_fail++; $display("FAIL single_done got=%b/%0d exp=1/2", done_valid, done_id); end
        step();
        n_checks++; if ({done_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL single_after got=%b exp=00", {done_valid, busy}); end
        n_checks++; if ({mp_matrix_addr, done_id} !== {16'h0100, 2'd2}) begin n_fail++; $display("FAIL single_hold got=%h/%0d exp=0100/2", mp_matrix_addr, done_id); end
        exp_ptr = 3;
    endtask

    task automatic test_fairness();
        int order [5] = '{0, 1, 2, 3, 0};
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            m_a[i] = AW'(16'h1000 + i); v_a[i] = AW'(16'h2000 + i); o_a[i] = AW'(16'h3000 + i); cnt[i] = CW'(i + 1);
        end
        req_valid = '1;
        for (int j = 0; j < 5; j++) begin
            #1;
            n_checks++; if (req_ready !== (4'b0001 << order[j])) begin n_fail++; $display("FAIL fair_grant j=%0d got=%b exp=%b", j, req_ready, 4'b0001 << order[j]); end
            step();
            n_checks++; if ({mp_start, mp_matrix_addr} !== {1'b1, m_a[order[j]]}) begin n_fail++; $display("FAIL fair_start j=%0d got=%b/%h exp=1/%h", j, mp_start, mp_matrix_addr, m_a[order[j]]); end
            step(); step(); step();
            mp_done = 1'b1;
            step();
            mp_done = 1'b0;
            n_checks++; if ({done_valid, done_id, req_ready} !== {1'b1, IW'(order[j]), 4'b0000})
                begin n_fail++; $display("FAIL fair_done j=%0d got=%b/%0d/%b exp=1/%0d/0000", j, done_valid, done_id, req_ready, order[j]); end
            step();
            exp_ptr = (order[j] + 1) % NREQ;
        end
        req_valid = '0;
    endtask

    task automatic test_zero_count();
        cnt[1] = '0;
        req_valid = 4'b0010;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL zero_ready got=%b exp=0010", req_ready); end
        step();
        req_valid = '0;
        n_checks++; if ({mp_start, done_valid, done_id} !== {1'b0, 1'b1, 2'd1}) begin n_fail++; $display("FAIL zero_done start/done/id got=%b/%b/%0d exp=0/1/1", mp_start, done_valid, done_id); end
        step();
        n_checks++; if ({mp_start, done_valid, busy} !== 3'b000) begin n_fail++; $display("FAIL zero_after got=%b exp=000", {mp_start, done_valid, busy}); end
        exp_ptr = 2;
    endtask

    task automatic test_spurious();
        req_valid = '0;
        mp_done = 1'b1;
        step();
        mp_done = 1'b0;
        exp_err = 1'b1;
        n_checks++; if ({err_spurious, done_valid, busy} !== 3'b100) begin n_fail++; $display("FAIL spur_flag err/done/busy got=%b exp=100", {err_spurious, done_valid, busy}); end
        step(); step(); step();
        n_checks++; if ({err_spurious, busy} !== 2'b10) begin n_fail++; $display("FAIL spur_sticky err/busy got=%b exp=10", {err_spurious, busy}); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        n_checks++; if (err_spurious !== 1'b0) begin n_fail++; $display("FAIL rmid_err_clear got=%b exp=0", err_spurious); end
        cnt[2] = 8'd7;
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        step();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_wait got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy_in_reset got=%b exp=0", busy); end
        step();
        rst_n = 1'b1;
        n_checks++; if ({busy, done_valid} !== 2'b00) begin n_fail++; $display("FAIL rmid_after got=%b exp=00", {busy, done_valid}); end
        mp_done = 1'b1;
        step();
        mp_done = 1'b0;
        n_checks++; if ({done_valid, err_spurious} !== 2'b01) begin n_fail++; $display("FAIL rmid_late_done done/err got=%b exp=01", {done_valid, err_spurious}); end
        req_valid = '1;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rmid_ptr got=%b exp=0001", req_ready); end
        req_valid = '0;
        step();
    endtask

    task automatic test_withdrawal();
        apply_reset();
        cnt[0] = 8'd4;
        req_valid = 4'b0001;
        step();
        req_valid = 4'b1000;
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL wd_ready_issue got=%b exp=0000", req_ready); end
        step();
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL wd_ready_wait got=%b exp=0000", req_ready); end
        req_valid = '0;
        step(); step();
        mp_done = 1'b1;
        step();
        mp_done = 1'b0;
        n_checks++; if ({done_valid, done_id} !== {1'b1, 2'd0}) begin n_fail++; $display("FAIL wd_done got=%b/%0d exp=1/0", done_valid, done_id); end
        step();
        n_checks++; if ({req_ready, busy} !== 5'b00000) begin n_fail++; $display("FAIL wd_idle got=%b exp=00000", {req_ready, busy}); end
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wd_not_granted busy got=%b exp=0", busy); end
        req_valid = 4'b0110;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL wd_next got=%b exp=0010", req_ready); end
        req_valid = '0;
        step();
    endtask

    task automatic test_random();
        int        w, lat;
        bit        spur;
        job_desc_t e;
        logic [NREQ-1:0] exp_ready;
        apply_reset();
        for (int it = 0; it < 80; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                m_a[i] = AW'($urandom); v_a[i] = AW'($urandom); o_a[i] = AW'($urandom);
                cnt[i] = ($urandom_range(0, 3) == 0) ? '0 : CW'($urandom_range(1, 255));
            end
            req_valid = NREQ'($urandom);
            #1;
            w = pick(req_valid, exp_ptr);
            exp_ready = (w < 0) ? '0 : (4'b0001 << w);
            n_checks++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready it=%0d got=%b exp=%b", it, req_ready, exp_ready); end
            if (w < 0) begin
                step();
                continue;
            end
            e = '{matrix: m_a[w], vector: v_a[w], out: o_a[w], count: cnt[w]};
            exp_ptr = (w + 1) % NREQ;
            spur = ($urandom_range(0, 3) == 0);
            step();
            req_valid = NREQ'($urandom);
            #1;
            n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rnd_busy_ready it=%0d got=%b exp=0000", it, req_ready); end
            if (e.count == '0) begin
                n_checks++; if ({mp_start, done_valid, done_id} !== {1'b0, 1'b1, IW'(w)}) begin n_fail++; $display("FAIL rnd_zero it=%0d got=%b/%b/%0d exp=0/1/%0d", it, mp_start, done_valid, done_id, w); end
                step();
                continue;
            end
            n_checks++; if ({mp_start, mp_matrix_addr, mp_vector_addr, mp_out_addr, mp_count} !== {1'b1, e})
                begin n_fail++; $display("FAIL rnd_start it=%0d got=%b/%h/%h/%h/%0d exp=1/%h/%h/%h/%0d", it, mp_start, mp_matrix_addr, mp_vector_addr, mp_out_addr, mp_count, e.matrix, e.vector, e.out, e.count); end
            if (spur) begin
                mp_done = 1'b1;
                exp_err = 1'b1;
            end
            lat = $urandom_range(1, 6);
            step();
            mp_done = 1'b0;
            for (int k = 1; k < lat; k++) begin
                m_a[w] = AW'($urandom);
                n_checks++; if ({done_valid, busy, mp_start} !== 3'b010) begin n_fail++; $display("FAIL rnd_wait it=%0d got=%b exp=010", it, {done_valid, busy, mp_start}); end
                step();
            end
            mp_done = 1'b1;
            step();
            mp_done = 1'b0;
            n_checks++; if ({done_valid, done_id, err_spurious, mp_matrix_addr} !== {1'b1, IW'(w), exp_err, e.matrix})
                begin n_fail++; $display("FAIL rnd_done it=%0d got=%b/%0d/%b/%h exp=1/%0d/%b/%h", it, done_valid, done_id, err_spurious, mp_matrix_addr, w, exp_err, e.matrix); end
            step();
        end
        req_valid = '0;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = '0; mp_done = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_zero_count();
        test_spurious();
        test_reset_mid();
        test_withdrawal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
